// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern source: H/V timing counters plus a registered colour stage.
// Patterns: colour bars, gray ramp, checkerboard and a bouncing box.
module lcd_pattern_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 21,
    parameter int SYNC_POL   = 0,
    parameter int R_W        = 5,
    parameter int G_W        = 6,
    parameter int B_W        = 5,
    parameter int BAR_NUM    = 16,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     mode_i,
    input  logic           en_i,
    output logic           lcd_hs,
    output logic           lcd_vs,
    output logic           lcd_de,
    output logic [R_W-1:0] lcd_r,
    output logic [G_W-1:0] lcd_g,
    output logic [B_W-1:0] lcd_b,
    output logic [11:0]    active_x,
    output logic [11:0]    active_y,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int RGB_W   = R_W + G_W + B_W;
    localparam int BW      = H_ACTIVE / BAR_NUM;

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BOX_X_MAX = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] BOX_Y_MAX = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [12:0] BOX_SZ    = 13'(BOX_SIZE);
    localparam logic [11:0] BW_LAST   = 12'(BW - 1);
    localparam logic [7:0]  BAR_LAST  = 8'(BAR_NUM - 1);
    localparam logic [7:0]  RGB_W8    = 8'(RGB_W);
    localparam logic        SYNC_ON   = (SYNC_POL != 0);

    localparam logic [RGB_W-1:0] RGB_MSB  = {1'b1, {(RGB_W-1){1'b0}}};
    localparam logic [RGB_W-1:0] RGB_BLUE = {{(R_W+G_W){1'b0}}, {B_W{1'b1}}};

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    logic [11:0]      hcnt, vcnt;
    logic [11:0]      sub_cnt;
    logic [7:0]       bar_k;
    mode_t            mode_q;
    logic [11:0]      box_x, box_y;
    dir_t             dir_x, dir_y;

    logic             de_c, hs_c, vs_c, frame_end, in_box;
    logic [RGB_W-1:0] rgb_c;

    assign de_c      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_c      = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_c      = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
    assign in_box    = (hcnt >= box_x) && ({1'b0, hcnt} < {1'b0, box_x} + BOX_SZ) &&
                       (vcnt >= box_y) && ({1'b0, vcnt} < {1'b0, box_y} + BOX_SZ);

    // NOTE: every variable written in always_comb gets a default first, so no latch can form.
    always_comb begin
        rgb_c = '0;
        if (de_c && en_i) begin
            case (mode_q)
                MODE_BARS:  rgb_c = (bar_k < RGB_W8) ? (RGB_MSB >> bar_k) : '1;
                MODE_RAMP:  rgb_c = {hcnt[7 -: R_W], hcnt[7 -: G_W], hcnt[7 -: B_W]};
                MODE_CHECK: rgb_c = (hcnt[CHECK_LOG2] == vcnt[CHECK_LOG2]) ? '1 : '0;
                MODE_BOX:   rgb_c = in_box ? '1 : RGB_BLUE;
                default:    rgb_c = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            sub_cnt     <= '0;
            bar_k       <= '0;
            mode_q      <= MODE_BARS;
            box_x       <= '0;
            box_y       <= '0;
            dir_x       <= DIR_INC;
            dir_y       <= DIR_INC;
            lcd_hs      <= ~SYNC_ON;
            lcd_vs      <= ~SYNC_ON;
            lcd_de      <= 1'b0;
            lcd_r       <= '0;
            lcd_g       <= '0;
            lcd_b       <= '0;
            active_x    <= '0;
            active_y    <= '0;
            frame_start <= 1'b0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
            end else begin
                hcnt <= hcnt + 12'd1;
            end

            // Bar index tracks hcnt / BW incrementally; restarts with the line.
            if (hcnt == H_LAST) begin
                sub_cnt <= '0;
                bar_k   <= '0;
            end else if (sub_cnt == BW_LAST) begin
                sub_cnt <= '0;
                if (bar_k != BAR_LAST) bar_k <= bar_k + 8'd1;
            end else begin
                sub_cnt <= sub_cnt + 12'd1;
            end

            // Frame boundary: pattern selection and box motion change only here.
            if (frame_end) begin
                mode_q <= mode_t'(mode_i);
                if (dir_x == DIR_INC) begin
                    if (box_x == BOX_X_MAX) begin
                        dir_x <= DIR_DEC;
                        box_x <= box_x - 12'd1;
                    end else begin
                        box_x <= box_x + 12'd1;
                    end
                end else begin
                    if (box_x == 12'd0) begin
                        dir_x <= DIR_INC;
                        box_x <= box_x + 12'd1;
                    end else begin
                        box_x <= box_x - 12'd1;
                    end
                end
                if (dir_y == DIR_INC) begin
                    if (box_y == BOX_Y_MAX) begin
                        dir_y <= DIR_DEC;
                        box_y <= box_y - 12'd1;
                    end else begin
                        box_y <= box_y + 12'd1;
                    end
                end else begin
                    if (box_y == 12'd0) begin
                        dir_y <= DIR_INC;
                        box_y <= box_y + 12'd1;
                    end else begin
                        box_y <= box_y - 12'd1;
                    end
                end
            end

            lcd_hs      <= hs_c ? SYNC_ON : ~SYNC_ON;
            lcd_vs      <= vs_c ? SYNC_ON : ~SYNC_ON;
            lcd_de      <= de_c;
            lcd_r       <= rgb_c[RGB_W-1 -: R_W];
            lcd_g       <= rgb_c[B_W +: G_W];
            lcd_b       <= rgb_c[B_W-1:0];
            active_x    <= de_c ? hcnt : 12'd0;
            active_y    <= de_c ? vcnt : 12'd0;
            frame_start <= (hcnt == 12'd0) && (vcnt == 12'd0);
        end
    end

endmodule
